// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, issues credit-limited imem requests,
// buffers in-order responses and hands {pc, instr} to decode; redirects flush and drop stale beats.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [31:0]          pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]        inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  ent_t [DEPTH-1:0]     mem_q, mem_d;
  logic [CW:0]          used;
  logic                 req_fire, pop, rsp, keep, empty;
  logic                 unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credit covers both in-flight requests and buffered entries, so the FIFO can never overflow.
  assign used           = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = rst_n && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_addr      = pc_q;

  assign empty    = (count_q == '0);
  assign id_valid = !empty && !redirect_valid;
  assign id_pc    = empty ? 32'h0 : mem_q[rd_ptr_q].pc;
  assign id_instr = empty ? 32'h0 : mem_q[rd_ptr_q].instr;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = id_valid && id_ready;
  // A beat with nothing outstanding is a protocol error and is ignored.
  assign rsp      = imem_rsp_valid && (inflight_q != '0);
  assign keep     = rsp && (drop_q == '0);

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Everything still outstanding after this cycle's beat belongs to the wrong path.
      inflight_d = inflight_q - CW'(rsp);
      drop_d     = inflight_q - CW'(rsp);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp);
      if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (keep) begin
        mem_d[wr_ptr_q] = '{pc: rsp_pc_q, instr: imem_rsp_data};
        wr_ptr_d        = wr_ptr_q + PW'(1);
        rsp_pc_d        = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based imem and fetch model checked every cycle,
// plus directed scenarios with hand-derived decode streams.
module tb_fetch_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  int errors = 0, checks = 0, cyc = 0, lat = 1, first_idv = -1;
  req_t        mq[$];
  ent_t        mfifo[$];
  logic [31:0] dlog[$], ilog[$];
  int          clog[$];
  logic [31:0] m_pc, m_rsp_pc;
  int          m_infl, m_drop;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: imem drives its beat, outputs are checked against the model,
  // then imem and model advance as the clock edge will.
  task automatic step();
    logic rsp, exp_rv, exp_idv, pop;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
    end
    #1;
    exp_rv  = !redirect_valid && (m_infl + mfifo.size() < DEPTH);
    exp_idv = (mfifo.size() != 0) && !redirect_valid;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(exp_idv));
    if (mfifo.size() != 0) begin
      chk("id_pc", id_pc, mfifo[0].pc);
      chk("id_instr", id_instr, mfifo[0].instr);
    end else begin
      chk("id_pc_empty", id_pc, 32'h0);
      chk("id_instr_empty", id_instr, 32'h0);
    end
    chk("count_bound", 32'(dut.count_q <= DEPTH), 32'd1);
    if (id_valid && id_ready) begin
      dlog.push_back(id_pc); ilog.push_back(id_instr); clog.push_back(cyc);
    end
    if (id_valid && first_idv < 0) first_idv = cyc;
    rsp = imem_rsp_valid;
    if (rsp) void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + lat});
    pop = exp_idv && id_ready;
    if (redirect_valid) begin
      m_pc     = {redirect_pc[31:2], 2'b00};
      m_rsp_pc = {redirect_pc[31:2], 2'b00};
      mfifo.delete();
      m_infl   = m_infl - (rsp ? 1 : 0);
      m_drop   = m_infl;
    end else begin
      if (pop) void'(mfifo.pop_front());
      if (rsp) begin
        m_infl--;
        if (m_drop > 0) m_drop--;
        else begin
          mfifo.push_back('{m_rsp_pc, instr_of(m_rsp_pc)});
          m_rsp_pc += 32'd4;
        end
      end
      if (exp_rv && imem_req_ready) begin
        m_pc += 32'd4;
        m_infl++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset mid-cycle; outputs must settle to reset values without a clock edge.
  task automatic hold_reset();
    #2;
    rst_n = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    mq.delete(); mfifo.delete();
    m_pc = RESET_PC; m_rsp_pc = RESET_PC; m_infl = 0; m_drop = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; cyc = 0; first_idv = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, bad;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

    // Streaming from reset: one instruction per cycle starting at cycle 2.
    lat = 1;
    hold_reset();
    run(12);
    chk("first_idv_cycle", 32'(first_idv), 32'd2);
    chk("stream_len", 32'(dlog.size()), 32'd10);
    for (int i = 0; i < dlog.size() && i < 10; i++) begin
      chk("stream_pc", dlog[i], 32'(i * 4));
      chk("stream_instr", ilog[i], instr_of(32'(i * 4)));
    end

    // Decode stall: four entries buffered, fetch stops on credit.
    id_ready = 1'b0;
    run(10);
    #1;
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_head_pc", id_pc, 32'h28);
    chk("stall_head_instr", id_instr, 32'hA5A5_0028);
    id_ready = 1'b1;
    n = dlog.size();
    run(8);
    chk("drain_count", 32'(dlog.size() - n >= 6), 32'd1);
    for (int i = 0; i < 6 && n + i < dlog.size(); i++)
      chk("drain_pc", dlog[n + i], 32'h28 + 32'(i * 4));

    // Slow imem, two requests in flight, redirect to 0x100.
    lat = 3;
    hold_reset();
    run(2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n = dlog.size();
    for (int i = 0; i < 20 && dlog.size() == n; i++) step();
    chk("r3_seen", 32'(dlog.size() > n), 32'd1);
    if (dlog.size() > n) begin
      chk("r3_pc", dlog[n], 32'h100);
      chk("r3_instr", ilog[n], 32'hA5A5_0100);
      chk("r3_cycle", 32'(clog[n]), 32'd7);
    end

    // Redirect on a response beat, then a second redirect right after; imem briefly not ready.
    lat = 1;
    hold_reset();
    run(5);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    n = dlog.size();
    imem_req_ready = 1'b0;
    run(2);
    imem_req_ready = 1'b1;
    run(8);
    chk("r2_seen", 32'(dlog.size() > n), 32'd1);
    if (dlog.size() > n) chk("r2_first_pc", dlog[n], 32'h200);
    bad = 0;
    for (int i = n; i < dlog.size(); i++)
      if (dlog[i] < 32'h200) bad++;
    chk("r2_no_stale", 32'(bad), 32'd0);

    // Misaligned target is aligned; PC wraps past 0xFFFF_FFFC.
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("align_addr", imem_addr, 32'h100);
    run(3);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    n = dlog.size();
    step();
    #1;
    chk("wrap_addr", imem_addr, 32'h0);
    run(5);
    chk("wrap_seen", 32'(dlog.size() >= n + 2), 32'd1);
    if (dlog.size() >= n + 2) begin
      chk("wrap_pc0", dlog[n], 32'hFFFF_FFFC);
      chk("wrap_pc1", dlog[n + 1], 32'h0);
    end

    // Reset mid-stream with two requests outstanding; restart from RESET_PC.
    lat = 3;
    hold_reset();
    run(2);
    hold_reset();
    n = dlog.size();
    run(8);
    chk("restart_first_idv", 32'(first_idv), 32'd4);
    chk("restart_seen", 32'(dlog.size() > n), 32'd1);
    if (dlog.size() > n) chk("restart_pc", dlog[n], RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode stage. It holds the program counter and issues word-aligned requests to instruction memory over a valid/ready channel. It buffers in-order responses in a small FIFO and presents `{pc, instr}` pairs to decode over a valid/ready handshake. On a redirect from a taken branch, `jal` or `jalr` it flushes the FIFO and silently drops every wrong-path response still in flight.

## Interface

Parameters:

- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 4: entries in the instruction FIFO, and also the cap on in-flight requests plus buffered entries. Power of two, ≥ 2.

Ports:

- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req_valid`, output, 1: fetch request.
- `imem_req_ready`, input, 1: imem accepts the request.
- `imem_addr`, output, 32: fetch address; always equals `pc_q`.
- `imem_rsp_valid`, input, 1: response beat; in order, at least 1 cycle after its request, never back-pressured.
- `imem_rsp_data`, input, 32: instruction word.
- `redirect_valid`, input, 1: pipeline redirect (taken branch, `jal`, `jalr`).
- `redirect_pc`, input, 32: redirect target; bits [1:0] are forced to 0 internally.
- `id_valid`, output, 1: an instruction is available to decode.
- `id_ready`, input, 1: decode accepts it.
- `id_instr`, output, 32: instruction word for decode.
- `id_pc`, output, 32: address of `id_instr`.

## Operation

State:

- `pc_q`: next fetch address.
- `rsp_pc_q`: address of the next expected kept response.
- `inflight_q`: issued requests not yet answered, 0..DEPTH.
- `drop_q`: wrong-path responses still to discard, always ≤ `inflight_q`.
- FIFO of `{pc, instr}` entries, with `count_q`.

Issue:

- `imem_req_valid = !redirect_valid && (inflight_q + count_q < DEPTH)`.
- On handshake (`imem_req_valid && imem_req_ready`): `pc_q += 4` (wraps modulo 2^32) and `inflight_q` increments.
- `imem_addr` may change while valid and not ready, but only on a redirect; imem samples the address only on handshake.

Response:

- Every `imem_rsp_valid` decrements `inflight_q`.
- If `drop_q != 0`: discard the beat and decrement `drop_q`.
- Otherwise: push `{rsp_pc_q, imem_rsp_data}` into the FIFO and do `rsp_pc_q += 4`.

Output:

- `id_valid = (count_q != 0) && !redirect_valid`.
- `id_instr` and `id_pc` come from the FIFO head.
- Pop on `id_valid && id_ready`.
- Push and pop in the same cycle leave `count_q` unchanged.

Redirect (takes priority over everything else in its cycle):

- `pc_q` and `rsp_pc_q` take `{redirect_pc[31:2], 2'b00}`.
- The FIFO is emptied (`count_q = 0`); no pop and no issue happen that cycle.
- `drop_q` takes `inflight_q - imem_rsp_valid`, so a beat arriving in the redirect cycle is itself discarded.
- `inflight_q` takes `inflight_q - imem_rsp_valid`.
- Back-to-back redirects: the last one wins; the drop count is recomputed each time.

Boundary conditions:

- FIFO overflow is impossible by the credit rule; the bench asserts `count_q ≤ DEPTH`.
- A response arriving with `inflight_q == 0` is a protocol error: assert in simulation, ignore in RTL.
- `drop_q` draining to 0 while the next kept response arrives in the same cycle is a correct handoff; the boundary beat is dropped or kept according to `drop_q` at the start of the cycle.

Reset:

- Asynchronous reset at any time: `pc_q = rsp_pc_q = RESET_PC`, `inflight_q = drop_q = count_q = 0`.
- The imem is reset by the same `rst_n`.

## Timing

- Reset values of outputs: `imem_req_valid = 0` while `rst_n` is low, then 1 in the first cycle after deassertion; `imem_addr = RESET_PC`; `id_valid = 0`; `id_instr = 0`; `id_pc = 0` (the FIFO head reads zero when empty).
- Fetch-to-decode latency, measured from issue with a 1-cycle imem: request handshake in cycle N, response in N+1, `id_valid` in N+2.
- Throughput: sustains 1 instruction per cycle with `DEPTH = 4`, a 1-cycle imem, and `id_ready` held high.
- Redirect latency: redirect asserted in cycle N gives `imem_addr = target` with `imem_req_valid` in N+1; the first target instruction reaches `id_valid` at N+3 or later.
- All credit and issue decisions use registered counts only; `id_ready` does not feed `imem_req_valid`.

## Test plan

- Reset release with a 1-cycle imem and `id_ready = 1`: decode receives pc `0x0, 0x4, 0x8, …`, one per cycle from cycle 2, each with matching data.
- `id_ready = 0` for 10 cycles: exactly 4 entries buffered, `imem_req_valid` drops once `inflight_q + count_q = 4`; on release the 4 entries drain in order with nothing lost or duplicated.
- Imem with 3-cycle latency, 2 requests in flight, redirect to `0x100`: both stale beats are dropped, and the next `id_pc` is `0x100` with its data.
- Redirect in the same cycle as a response beat, and a second redirect to `0x200` one cycle after a first to `0x100`: only `0x200`-path instructions appear at decode.
- `redirect_pc = 0x103`: the fetch address is `0x100`. `pc_q = 0xFFFF_FFFC` wraps to `0x0` on the next issue.
- `rst_n` pulsed low mid-stream with 2 in flight: all outputs return to reset values asynchronously, and fetching restarts at `RESET_PC`.
